// File: rtl/video_timing_gen.sv
// Raster timing generator: per-axis active/porch/sync counters on a pixel enable,
// frame-latched centering offsets, line/frame strobes. Optional flip: `VTG_FLIP_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 23,
  parameter int H_SYNC   = 31,
  parameter int H_BP     = 42,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 29,
  parameter int CNT_W    = 9,
  parameter int RGB_W    = 12,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk_sys,
  input  logic             RESET,
  input  logic             ce_pix,
  input  logic [3:0]       h_adj,
  input  logic [3:0]       v_adj,
`ifdef VTG_FLIP_EN
  input  logic             flip,
`endif
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BASE = H_ACTIVE + H_FP;
  localparam int VS_BASE = V_ACTIVE + V_FP;
  localparam int XW      = CNT_W + 2;

  logic [CNT_W-1:0] hcnt, vcnt;
  logic [3:0]       h_adj_q, v_adj_q;
  logic             h_end, v_end;
  logic             h_blank_d, v_blank_d, blank_d;
  logic             h_sync_d, v_sync_d;
  logic [XW-1:0]    hs0, vs0, hcnt_x, vcnt_x;

  assign h_end = (hcnt == CNT_W'(H_TOTAL - 1));
  assign v_end = (vcnt == CNT_W'(V_TOTAL - 1));

  // Sync start is widened so a negative offset sign-extends cleanly before compare
  always_comb begin
    hcnt_x    = {2'b00, hcnt};
    vcnt_x    = {2'b00, vcnt};
    hs0       = XW'(HS_BASE) + {{(XW-4){h_adj_q[3]}}, h_adj_q};
    vs0       = XW'(VS_BASE) + {{(XW-4){v_adj_q[3]}}, v_adj_q};
    h_sync_d  = (hcnt_x >= hs0) && (hcnt_x < hs0 + XW'(H_SYNC));
    v_sync_d  = (vcnt_x >= vs0) && (vcnt_x < vs0 + XW'(V_SYNC));
    h_blank_d = (hcnt >= CNT_W'(H_ACTIVE));
    v_blank_d = (vcnt >= CNT_W'(V_ACTIVE));
    blank_d   = h_blank_d | v_blank_d;
  end

`ifdef VTG_FLIP_EN
  logic flip_q;
`endif

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      hcnt        <= '0;
      vcnt        <= '0;
      h_adj_q     <= '0;
      v_adj_q     <= '0;
`ifdef VTG_FLIP_EN
      flip_q      <= 1'b0;
`endif
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      rgb_out     <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes are one clk_sys wide, so they clear even when ce_pix is low
      line_start  <= ce_pix & h_end;
      frame_start <= ce_pix & h_end & v_end;
      if (ce_pix) begin
        hcnt <= h_end ? '0 : hcnt + CNT_W'(1);
        if (h_end)
          vcnt <= v_end ? '0 : vcnt + CNT_W'(1);
        if (h_end && v_end) begin
          h_adj_q <= h_adj;
          v_adj_q <= v_adj;
`ifdef VTG_FLIP_EN
          flip_q  <= flip;
`endif
        end
        hblank  <= h_blank_d;
        vblank  <= v_blank_d;
        de      <= ~blank_d;
        rgb_out <= blank_d ? '0 : rgb_in;
        hsync   <= h_sync_d ^ ~SYNC_POL;
        if (hcnt == '0)
          vsync <= v_sync_d ^ ~SYNC_POL;
      end
    end
  end

  always_comb begin
    hpos = hcnt;
    vpos = vcnt;
`ifdef VTG_FLIP_EN
    if (flip_q && !h_blank_d && !v_blank_d) begin
      hpos = CNT_W'(H_ACTIVE - 1) - hcnt;
      vpos = CNT_W'(V_ACTIVE - 1) - vcnt;
    end
`endif
  end

endmodule
